lsram_fifo_ctrl: RTL



---
 rtl/lsram_fifo_ctrl.sv | 85 ++++++++
 1 files changed

// File: rtl/lsram_fifo_ctrl.sv
// lsram_fifo_ctrl: FWFT FIFO controller for a two-port LSRAM, with a 2-entry
// output buffer that hides the RAM's 1-cycle read latency.
module lsram_fifo_ctrl #(
  parameter int DATA_WIDTH    = 40,
  parameter int ADDR_WIDTH    = 10,
  parameter int AFULL_THRESH  = 1000,
  parameter int AEMPTY_THRESH = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  WE,
  input  logic [DATA_WIDTH-1:0] DATA,
  input  logic                  RE,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  AFULL,
  output logic                  AEMPTY,
  output logic [ADDR_WIDTH+1:0] COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  output logic [ADDR_WIDTH-1:0] RAM_W_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_W_DATA,
  output logic                  RAM_W_EN,
  output logic [ADDR_WIDTH-1:0] RAM_R_ADDR,
  output logic                  RAM_R_EN,
  input  logic [DATA_WIDTH-1:0] RAM_R_DATA
);
  localparam logic [ADDR_WIDTH:0]   LP_DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LP_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH+1:0] LP_AFULL  = (ADDR_WIDTH+2)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH+1:0] LP_AEMPTY = (ADDR_WIDTH+2)'(AEMPTY_THRESH);
  logic [ADDR_WIDTH:0]   r_wr_ptr, r_rd_ptr, w_ram_words;
  logic                  r_pend, r_ovf, r_unf;
  logic [1:0]            r_ocnt;
  logic [DATA_WIDTH-1:0] r_q0, r_q1;
  logic                  w_push, w_pop, w_ren, w_wpos;
  logic [2:0]            w_occ;
  always_comb begin
    w_ram_words = r_wr_ptr - r_rd_ptr;
    FULL        = w_ram_words == LP_DEPTH;
    EMPTY       = r_ocnt == 2'd0;
    w_push      = WE & ~FULL & ~RESET;
    w_pop       = RE & ~EMPTY;
    w_occ       = {1'b0, r_ocnt} + {2'b0, r_pend};
    w_ren       = ~RESET & (w_ram_words != '0) & (w_occ < 3'd2 + {2'b0, w_pop});
    // ocnt + pend never exceeds 2, so a capture always lands in slot 0 or 1
    w_wpos      = r_ocnt[0] & ~w_pop;
    COUNT       = {1'b0, w_ram_words} + {{(ADDR_WIDTH+1){1'b0}}, r_pend} + {{ADDR_WIDTH{1'b0}}, r_ocnt};
    AFULL       = COUNT >= LP_AFULL;
    AEMPTY      = COUNT <= LP_AEMPTY;
    Q           = r_q0;
    OVERFLOW    = r_ovf;
    UNDERFLOW   = r_unf;
    RAM_W_EN    = w_push;
    RAM_W_ADDR  = r_wr_ptr[ADDR_WIDTH-1:0];
    RAM_W_DATA  = DATA;
    RAM_R_EN    = w_ren;
    RAM_R_ADDR  = r_rd_ptr[ADDR_WIDTH-1:0];
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_pend   <= 1'b0;
      r_ocnt   <= 2'd0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LP_ONE;
      if (w_ren) r_rd_ptr <= r_rd_ptr + LP_ONE;
      r_pend <= w_ren;
      r_ocnt <= r_ocnt + {1'b0, r_pend} - {1'b0, w_pop};
      r_ovf  <= WE & FULL;
      r_unf  <= RE & EMPTY;
    end
  end
  always_ff @(posedge CLK) begin
    if (w_pop) r_q0 <= r_q1;
    if (r_pend) begin
      if (w_wpos) r_q1 <= RAM_R_DATA;
      else r_q0 <= RAM_R_DATA;
    end
  end
endmodule
